// File: rtl/oc_15_pkg.sv
// Shared widths and count type for the 15-input population counter.
package oc_15_pkg;

    localparam int unsigned OC_N_IN    = 15;
    localparam int unsigned OC_CNT_W   = 4;
    localparam int unsigned OC_CNT_MAX = 15;

    typedef logic [OC_CNT_W-1:0] oc_cnt_t;

endpackage

// File: rtl/oc_15_full_adder.sv
// One-bit full adder: the 3:2 compressor cell of the counting tree.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/oc_15.sv
// 15-input population counter with a one-cycle registered result.
// Optional flags all_one/all_zero are built only when OC_15_FLAGS_EN is defined.
module oc_15
    import oc_15_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
    input  logic i,
    input  logic j,
    input  logic k,
    input  logic l,
    input  logic m,
    input  logic n,
    input  logic o,
    output logic w3,
    output logic w2,
    output logic w1,
    output logic w0,
    input  logic clk,
    input  logic rst_n
`ifdef OC_15_FLAGS_EN
    ,
    output logic all_one,
    output logic all_zero
`endif
);

    logic [OC_N_IN-1:0] din;
    assign din = {o, n, m, l, k, j, i, h, g, f, e, d, c, b, a};

    // Weight-1 column: five adders fold the 15 inputs into 5 sums and 5 carries.
    logic [4:0] s1;
    logic [4:0] c1;

    for (genvar gi = 0; gi < 5; gi++) begin : g_lvl1
        full_adder u_fa (
            .a    (din[3*gi]),
            .b    (din[3*gi+1]),
            .cin  (din[3*gi+2]),
            .s    (s1[gi]),
            .cout (c1[gi])
        );
    end

    // Weight-1 column continued: 5 sums reduce to the LSB plus two more carries.
    logic s6, c6, bit0, c7;

    full_adder u_fa6 (.a(s1[0]), .b(s1[1]), .cin(s1[2]), .s(s6),   .cout(c6));
    full_adder u_fa7 (.a(s1[3]), .b(s1[4]), .cin(s6),    .s(bit0), .cout(c7));

    // Weight-2 column: seven bits (c1[4:0], c6, c7) reduce to bit 1 and three carries.
    logic s8, c8, s9, c9, bit1, c10;

    full_adder u_fa8  (.a(c1[0]), .b(c1[1]), .cin(c1[2]), .s(s8),   .cout(c8));
    full_adder u_fa9  (.a(c1[3]), .b(c1[4]), .cin(c6),    .s(s9),   .cout(c9));
    full_adder u_fa10 (.a(s8),    .b(s9),    .cin(c7),    .s(bit1), .cout(c10));

    // Weight-4 column: three carries give bit 2 and the weight-8 carry.
    logic bit2, bit3;

    full_adder u_fa11 (.a(c8), .b(c9), .cin(c10), .s(bit2), .cout(bit3));

    oc_cnt_t cnt_d;
    oc_cnt_t cnt_q;

    assign cnt_d = {bit3, bit2, bit1, bit0};

    // Count register; reset wins over the sampled data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w3 = cnt_q[3];
    assign w2 = cnt_q[2];
    assign w1 = cnt_q[1];
    assign w0 = cnt_q[0];

`ifdef OC_15_FLAGS_EN
    // Flag registers share the count's latency and reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_one  <= 1'b0;
            all_zero <= 1'b0;
        end else begin
            all_one  <= (cnt_d == OC_CNT_W'(OC_CNT_MAX));
            all_zero <= (cnt_d == '0);
        end
    end
`endif

endmodule

// File: tb/tb_oc_15.sv
// Self-checking bench for oc_15: vector table, hand sequences and random run,
// with expected counts queued at drive time and compared after the next edge.
module tb_oc_15;

    logic        clk;
    logic        rst_n;
    logic [14:0] din;
    logic        w3, w2, w1, w0;
`ifdef OC_15_FLAGS_EN
    logic        all_one, all_zero;
`endif

    oc_15 dut (
        .a(din[0]),  .b(din[1]),  .c(din[2]),  .d(din[3]),  .e(din[4]),
        .f(din[5]),  .g(din[6]),  .h(din[7]),  .i(din[8]),  .j(din[9]),
        .k(din[10]), .l(din[11]), .m(din[12]), .n(din[13]), .o(din[14]),
        .w3(w3), .w2(w2), .w1(w1), .w0(w0),
        .clk(clk), .rst_n(rst_n)
`ifdef OC_15_FLAGS_EN
        , .all_one(all_one), .all_zero(all_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       one;
        logic       zero;
        string      name;
    } exp_t;

    typedef struct {
        logic [14:0] vin;
        logic        rst;
        logic [3:0]  cnt;
        string       name;
    } vec_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference count, written independently of the adder tree.
    function automatic logic [3:0] ref_count(input logic [14:0] v);
        int s;
        s = 0;
        for (int b = 0; b < 15; b++) s += int'(v[b]);
        return 4'(s);
    endfunction

    // Drive one cycle of stimulus and queue what must appear after the next edge.
    task automatic step(input logic [14:0] vin, input logic rst, input string name);
        exp_t x;
        @(negedge clk);
        din   = vin;
        rst_n = rst;
        x.cnt  = rst ? ref_count(vin) : 4'd0;
        x.one  = rst && (ref_count(vin) == 4'd15);
        x.zero = rst && (ref_count(vin) == 4'd0);
        x.name = name;
        q.push_back(x);
    endtask

    // Compare one queued expectation per clock, just after the edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if ({w3, w2, w1, w0} !== x.cnt) begin
                errors++;
                $display("FAIL %s: count got %b expected %b", x.name, {w3, w2, w1, w0}, x.cnt);
            end
`ifdef OC_15_FLAGS_EN
            checks++;
            if (all_one !== x.one || all_zero !== x.zero) begin
                errors++;
                $display("FAIL %s flags: got one=%b zero=%b expected one=%b zero=%b",
                         x.name, all_one, all_zero, x.one, x.zero);
            end
`endif
        end
    end

    vec_t vt[$];

    initial begin
        logic [14:0] acc;
        din   = '0;
        rst_n = 1'b0;

        // Table of fixed patterns with hand-derived counts.
        vt.push_back('{15'h7FFF, 1'b0, 4'd0,  "rst_all_ones_1"});
        vt.push_back('{15'h7FFF, 1'b0, 4'd0,  "rst_all_ones_2"});
        vt.push_back('{15'h0000, 1'b1, 4'd0,  "all_zero"});
        vt.push_back('{15'h5555, 1'b1, 4'd8,  "alt_5555"});
        vt.push_back('{15'h2AAA, 1'b1, 4'd7,  "alt_2AAA"});
        vt.push_back('{15'h7FFF, 1'b1, 4'd15, "all_ones"});
        vt.push_back('{15'h7FFE, 1'b1, 4'd14, "clear_a"});
        vt.push_back('{15'h7FFC, 1'b1, 4'd13, "clear_b"});
        vt.push_back('{15'h7FFF, 1'b1, 4'd15, "back_to_15"});
        vt.push_back('{15'h0000, 1'b1, 4'd0,  "15_to_0"});
        vt.push_back('{15'h7FFF, 1'b1, 4'd15, "0_to_15"});
        vt.push_back('{15'h7FFF, 1'b0, 4'd0,  "mid_reset"});
        vt.push_back('{15'h4321, 1'b1, 4'd5,  "after_reset"});
        vt.push_back('{15'h0F0F, 1'b1, 4'd8,  "nibbles"});
        vt.push_back('{15'h7000, 1'b1, 4'd3,  "top3"});

        foreach (vt[idx]) begin
            checks++;
            if ((vt[idx].rst ? ref_count(vt[idx].vin) : 4'd0) !== vt[idx].cnt) begin
                errors++;
                $display("FAIL table_%s: model %0d expected %0d", vt[idx].name,
                         ref_count(vt[idx].vin), vt[idx].cnt);
            end
            step(vt[idx].vin, vt[idx].rst, vt[idx].name);
        end

        // Cumulative raise a..o, one new bit every 10 cycles.
        acc = '0;
        for (int b = 0; b < 15; b++) begin
            acc[b] = 1'b1;
            for (int r = 0; r < 10; r++) step(acc, 1'b1, "ramp");
        end

        // Single-bit walk.
        for (int b = 0; b < 15; b++) begin
            step(15'(1) << b, 1'b1, "walk");
        end

        // Random run with periodic reset pulses.
        for (int r = 0; r < 10000; r++) begin
            step(15'($urandom), (r % 2500) != 1234, "random");
        end

        step(15'h0000, 1'b1, "tail");
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oc_15.md
OC_15 -- requirements
Module: oc_15

Interface
REQ-001 Parameters: none; widths fixed (15 inputs, 4-bit count).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 a  input  1  data bit 0 (weight 1, like all data bits).
REQ-005 b, c, d, e, f, g, h, i, j, k, l, m, n  input  1 each  data bits 1..13; port order follows the letters.
REQ-006 o  input  1  data bit 14.
REQ-007 w3  output  1  count MSB (weight 8).
REQ-008 w2  output  1  count bit, weight 4.
REQ-009 w1  output  1  count bit, weight 2.
REQ-010 w0  output  1  count LSB, weight 1.
REQ-011 Port order: a..o, then w3, w2, w1, w0, then clk, rst_n, then any flag outputs enabled by REQ-024.

Function
REQ-012 {w3,w2,w1,w0} SHALL equal the number of 1s among a..o sampled at the previous rising clk edge (population count, 0..15).
REQ-013 Latency: exactly 1 clock from input sample to output.
- No combinational path from inputs to outputs.
REQ-014 Count SHALL be exact for all 2^15 input patterns.
- Range 0..15 fits 4 bits: no overflow, no saturation, no wrap-around.
REQ-015 Every clk edge with rst_n=1 SHALL update the output.
- No enable and no handshake.
- Identical consecutive inputs give an unchanged output.
REQ-016 Input position SHALL NOT affect the result.
- Any permutation of a..o gives the same count.
REQ-017 Multiple bits toggling in one cycle SHALL be reflected together on the next edge.
- No intermediate values are visible.
- Example: count 15 to 0 in one step.

Reset
REQ-018 When rst_n=0 at a rising clk edge, w3..w0 SHALL become 0000 at that edge.
REQ-019 Flag outputs, if present, SHALL reset to 0.
REQ-020 Reset SHALL override data.
- Inputs sampled at a reset edge are discarded.
REQ-021 The first edge with rst_n=1 SHALL capture the current inputs normally.
REQ-022 Reset asserted mid-stream SHALL clear outputs at the next edge, regardless of input values.
REQ-023 Output values before the first clk edge are undefined.

Configuration
REQ-024 Macro OC_15_FLAGS_EN SHALL be supported.
- Defined: adds outputs all_one (1 when count==15) and all_zero (1 when count==0), 1 bit each.
- Flags are registered with the same 1-cycle latency as the count.
- Flags reset to 0.
- Undefined: the flag ports and their logic do not exist.
- Count behaviour is identical either way.

Structure
REQ-025 Shared package oc_15_pkg SHALL hold:
- OC_N_IN = 15;
- OC_CNT_W = 4;
- OC_CNT_MAX = 15;
- typedef oc_cnt_t, 4-bit unsigned.
REQ-026 Counting SHALL use a sub-module full_adder (inputs a, b, cin; outputs s, cout), instantiated in a carry-save tree.
- 11 instances compress 15 bits to the 4-bit count.
- The tree output is registered in oc_15.

Verification
REQ-027 rst_n=0 for 2 edges with all inputs=1 -> w3..w0=0000 after each edge (and all_one=0).
REQ-028 Release reset, all inputs 0 -> 0000, all_zero=1 when enabled.
REQ-029 Raise a, b, c, ... o one per 10 cycles (cumulative) -> output steps 1,2,...,15, each one edge after the change; all_one=1 at 15.
REQ-030 From all-ones, clear a then b -> 14 (1110), then 13 (1101).
REQ-031 Single-bit walk (only bit k=1, k=0..14) -> 0001 every time; alternating patterns 0x5555 and 0x2AAA (15-bit) -> 8 and 7.
REQ-032 Random 10,000 vectors, reset pulsed mid-run -> output matches a popcount model delayed 1 cycle; 0000 on the edge after each reset.
